// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch queue.
package ifu_pkg;

    localparam int          MAX_XLEN         = 64;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] PC_STEP          = 64'd4;

    // Queue entries carry a full-width PC; narrower cores use the low XLEN bits.
    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [31:0]         instr;
    } fq_entry_t;

endpackage

// File: rtl/ifu_fq_if.sv
// Memory-port and decode-port handshakes of the fetch unit; master is the IFU side.
interface ifu_fq_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_snxt_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_instr,
        output out_valid, out_pc, out_instr, out_snxt_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_instr,
        input  out_valid, out_pc, out_instr, out_snxt_pc,
        output out_ready
    );
endinterface

// File: rtl/ifu_fq_fifo.sv
// Synchronous FIFO of fetch entries; extra pointer bit distinguishes full from empty.
module ifu_fq_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  fq_entry_t              i_data,
    output fq_entry_t              o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    fq_entry_t   r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_push;
    logic        w_pop;

    assign w_pop   = i_pop & ~o_empty;
    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count = r_wptr - r_rptr;
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    // Read/write pointers with reset and flush.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Entry storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ifu_fq.sv
// Instruction fetch unit with decoupled fetch queue, credit-limited requests and redirect squash.
// Optional same-cycle response bypass to decode is enabled by defining IFU_FQ_BYPASS_EN.
module ifu_fq
    import ifu_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          FQ_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_redirect_en,
    input  logic [XLEN-1:0]           i_redirect_pc,
    ifu_fq_if.master                  bus,
    output logic [$clog2(FQ_DEPTH):0] o_fq_count
);
    localparam int              CW     = $clog2(FQ_DEPTH) + 1;
    localparam logic [XLEN-1:0] RST_PC = RESET_PC[XLEN-1:0];
    localparam logic [XLEN-1:0] STEP   = XLEN'(PC_STEP);
    localparam logic [CW:0]     LIMIT  = (CW+1)'(FQ_DEPTH);
    localparam logic [CW-1:0]   ONE    = CW'(1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occupancy;
    logic            w_credit;
    logic            w_req_fire;
    logic            w_rsp_fire;
    logic            w_dropping;
    logic            w_rsp_keep;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    fq_entry_t       w_wr_entry;
    fq_entry_t       w_head;
    logic [XLEN-1:0] w_out_pc;
    logic [31:0]     w_out_instr;

    // Squashed responses still occupy credit until they return.
    assign w_occupancy        = {1'b0, r_inflight} + {1'b0, w_count};
    assign w_credit           = (w_occupancy < LIMIT);
    assign bus.imem_req_valid = i_rstn & ~i_redirect_en & w_credit;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign w_req_fire         = bus.imem_req_valid & bus.imem_req_ready;

    assign w_rsp_fire = bus.imem_rsp_valid;
    assign w_dropping = (r_drop_cnt != '0);
    assign w_rsp_keep = w_rsp_fire & ~w_dropping & ~i_redirect_en;
    assign w_wr_entry = '{pc: MAX_XLEN'(r_rsp_pc), instr: bus.imem_rsp_instr};
    assign w_pop      = ~w_empty & bus.out_ready & ~i_redirect_en;

`ifdef IFU_FQ_BYPASS_EN
    logic w_bypass;
    // An empty queue lets a live response go straight to decode; it is stored only if not taken.
    assign w_bypass      = w_rsp_keep & w_empty;
    assign w_accept      = w_rsp_keep & ~(w_bypass & bus.out_ready);
    assign bus.out_valid = i_rstn & (~w_empty | w_bypass);
    assign w_out_pc      = w_empty ? r_rsp_pc : w_head.pc[XLEN-1:0];
    assign w_out_instr   = w_empty ? bus.imem_rsp_instr : w_head.instr;
`else
    assign w_accept      = w_rsp_keep;
    assign bus.out_valid = i_rstn & ~w_empty;
    assign w_out_pc      = w_head.pc[XLEN-1:0];
    assign w_out_instr   = w_head.instr;
`endif

    assign w_push          = w_accept & (~w_full | w_pop);
    assign bus.out_pc      = w_out_pc;
    assign bus.out_instr   = w_out_instr;
    assign bus.out_snxt_pc = w_out_pc + STEP;
    assign o_fq_count      = w_count;

    ifu_fq_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (i_redirect_en),
        .i_data  (w_wr_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Fetch/response PCs, outstanding-request count and squash counter.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_fetch_pc <= RST_PC;
            r_rsp_pc   <= RST_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else if (i_redirect_en) begin
            r_fetch_pc <= i_redirect_pc;
            r_rsp_pc   <= i_redirect_pc;
            r_inflight <= r_inflight - CW'(w_rsp_fire);
            r_drop_cnt <= r_inflight - CW'(w_rsp_fire);
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + STEP;
            if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + STEP;
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_fire);
            if (w_rsp_fire && w_dropping) r_drop_cnt <= r_drop_cnt - ONE;
        end
    end

endmodule

// File: tb/tb_ifu_fq.sv
// Directed bench for ifu_fq: fixed-latency memory model, scenario tasks with inline checks.
module tb_ifu_fq;
    import ifu_pkg::*;

`ifdef IFU_FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect_en = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic [2:0]  fq_count;

    ifu_fq_if #(.XLEN(64)) ifc ();

    ifu_fq #(
        .XLEN     (64),
        .RESET_PC (64'h8000_0000),
        .FQ_DEPTH (4)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_redirect_en (redirect_en),
        .i_redirect_pc (redirect_pc),
        .bus           (ifc),
        .o_fq_count    (fq_count)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Memory model state
    int          mem_lat = 1;
    int          acc_cnt = 0;
    longint      cyc = 0;
    logic [63:0] pend_addr[$];
    longint      pend_due[$];
    logic        m_fire;
    logic [63:0] m_addr;

    function automatic logic [31:0] memfn(input logic [63:0] a);
        return 32'h0000_0013 | {a[11:0], 20'h00000};
    endfunction

    // In-order memory: a request accepted at an edge answers mem_lat cycles later.
    initial begin
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_instr = 32'd0;
        forever begin
            @(posedge clk);
            m_fire = ifc.imem_req_valid & ifc.imem_req_ready;
            m_addr = ifc.imem_req_addr;
            cyc = cyc + 1;
            #1;
            if (!rstn) begin
                pend_addr.delete();
                pend_due.delete();
                ifc.imem_rsp_valid = 1'b0;
            end else begin
                if (m_fire) begin
                    pend_addr.push_back(m_addr);
                    pend_due.push_back(cyc + longint'(mem_lat) - 1);
                    acc_cnt = acc_cnt + 1;
                end
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    ifc.imem_rsp_valid = 1'b1;
                    ifc.imem_rsp_instr = memfn(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    ifc.imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    task automatic do_reset(input int lat, input logic rdy, input logic ordy);
        @(negedge clk);
        rstn = 1'b0;
        redirect_en = 1'b0;
        mem_lat = lat;
        ifc.imem_req_ready = rdy;
        ifc.out_ready = ordy;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        ifc.imem_req_ready = 1'b0;
        ifc.out_ready = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ifc.imem_req_valid !== 1'b0 || ifc.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valids: req_valid=%b out_valid=%b want 0/0", ifc.imem_req_valid, ifc.out_valid);
        end
        tests_run++;
        if (fq_count !== 3'd0 || ifc.imem_req_addr !== 64'h8000_0000) begin
            tests_failed++;
            $display("FAIL reset_state: fq_count=%0d addr=%h want 0/80000000", fq_count, ifc.imem_req_addr);
        end
        rstn = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h8000_0000) begin
            tests_failed++;
            $display("FAIL first_request: valid=%b addr=%h want 1/80000000", ifc.imem_req_valid, ifc.imem_req_addr);
        end
    endtask

    task automatic test_stream();
        int first;
        logic [63:0] exp;
        first = BYP ? 1 : 2;
        do_reset(1, 1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp = 64'h8000_0000 + 64'(4 * (k - first));
            tests_run++;
            if (k < first) begin
                if (ifc.out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stream_latency: out_valid=%b at cycle %0d want 0", ifc.out_valid, k);
                end
            end else if (ifc.out_valid !== 1'b1 || ifc.out_pc !== exp || ifc.out_instr !== memfn(exp) || ifc.out_snxt_pc !== exp + 64'd4) begin
                tests_failed++;
                $display("FAIL stream_out: valid=%b pc=%h instr=%h snxt=%h want pc=%h instr=%h", ifc.out_valid, ifc.out_pc, ifc.out_instr, ifc.out_snxt_pc, exp, memfn(exp));
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        logic [63:0] exp;
        do_reset(1, 1'b1, 1'b0);
        base = acc_cnt;
        repeat (8) @(negedge clk);
        tests_run++;
        if (acc_cnt - base !== 4 || ifc.imem_req_valid !== 1'b0 || fq_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL bp_full: reqs=%0d req_valid=%b fq_count=%0d want 4/0/4", acc_cnt - base, ifc.imem_req_valid, fq_count);
        end
        tests_run++;
        if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 64'h8000_0000) begin
            tests_failed++;
            $display("FAIL bp_head: valid=%b pc=%h want 1/80000000", ifc.out_valid, ifc.out_pc);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h8000_0010) begin
            tests_failed++;
            $display("FAIL bp_resume: valid=%b addr=%h want 1/80000010", ifc.imem_req_valid, ifc.imem_req_addr);
        end
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            exp = 64'h8000_0004 + 64'(4 * k);
            tests_run++;
            if (ifc.out_valid !== 1'b1 || ifc.out_pc !== exp) begin
                tests_failed++;
                $display("FAIL bp_drain: valid=%b pc=%h want 1/%h", ifc.out_valid, ifc.out_pc, exp);
            end
        end
    endtask

    task automatic test_stall();
        int base;
        int n;
        logic [63:0] exp;
        do_reset(1, 1'b0, 1'b1);
        base = acc_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h8000_0000 || acc_cnt !== base) begin
                tests_failed++;
                $display("FAIL stall_hold: valid=%b addr=%h reqs=%0d want 1/80000000/0", ifc.imem_req_valid, ifc.imem_req_addr, acc_cnt - base);
            end
        end
        ifc.imem_req_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ifc.imem_req_addr !== 64'h8000_0004 || acc_cnt !== base + 1) begin
            tests_failed++;
            $display("FAIL stall_release: addr=%h reqs=%0d want 80000004/1", ifc.imem_req_addr, acc_cnt - base);
        end
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (ifc.out_valid === 1'b1 && n < 3) begin
                exp = 64'h8000_0000 + 64'(4 * n);
                tests_run++;
                if (ifc.out_pc !== exp) begin
                    tests_failed++;
                    $display("FAIL stall_order: pc=%h want %h", ifc.out_pc, exp);
                end
                n++;
            end
        end
        tests_run++;
        if (n !== 3) begin
            tests_failed++;
            $display("FAIL stall_timeout: got %0d outputs want 3", n);
        end
    endtask

    // Waits (bounded) for the next two outputs after a redirect and checks them.
    task automatic test_redirect();
        int n;
        logic [63:0] exp;
        do_reset(3, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        redirect_pc = 64'h8000_1000;
        redirect_en = 1'b1;
        #1;
        tests_run++;
        if (ifc.imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_req_block: req_valid=%b want 0", ifc.imem_req_valid);
        end
        @(negedge clk);
        tests_run++;
        if (ifc.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_out_valid: out_valid=%b want 0", ifc.out_valid);
        end
        redirect_en = 1'b0;
        #1;
        tests_run++;
        if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h8000_1000) begin
            tests_failed++;
            $display("FAIL redir_req: valid=%b addr=%h want 1/80001000", ifc.imem_req_valid, ifc.imem_req_addr);
        end
        n = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ifc.out_valid === 1'b1 && n < 2) begin
                exp = 64'h8000_1000 + 64'(4 * n);
                tests_run++;
                if (ifc.out_pc !== exp || ifc.out_instr !== memfn(exp)) begin
                    tests_failed++;
                    $display("FAIL redir_first_out: pc=%h instr=%h want %h/%h", ifc.out_pc, ifc.out_instr, exp, memfn(exp));
                end
                n++;
            end
        end
        tests_run++;
        if (n !== 2) begin
            tests_failed++;
            $display("FAIL redir_timeout: got %0d outputs want 2", n);
        end
    endtask

    task automatic test_redirect_pop();
        int n;
        do_reset(3, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        tests_run++;
        if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 64'h8000_0000 || ifc.imem_rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rp_setup: out_valid=%b pc=%h rsp_valid=%b want 1/80000000/1", ifc.out_valid, ifc.out_pc, ifc.imem_rsp_valid);
        end
        ifc.out_ready = 1'b1;
        redirect_pc = 64'h8000_2000;
        redirect_en = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ifc.out_valid !== 1'b0 || fq_count !== 3'd0 || dut.r_drop_cnt !== 3'd2) begin
            tests_failed++;
            $display("FAIL rp_state: out_valid=%b fq_count=%0d drop_cnt=%0d want 0/0/2", ifc.out_valid, fq_count, dut.r_drop_cnt);
        end
        redirect_en = 1'b0;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ifc.out_valid === 1'b1 && n < 1) begin
                tests_run++;
                if (ifc.out_pc !== 64'h8000_2000) begin
                    tests_failed++;
                    $display("FAIL rp_first_out: pc=%h want 80002000", ifc.out_pc);
                end
                n++;
            end
        end
        tests_run++;
        if (n !== 1) begin
            tests_failed++;
            $display("FAIL rp_timeout: got %0d outputs want 1", n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [63:0] exp;
        do_reset(2, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ifc.imem_req_valid !== 1'b0 || ifc.out_valid !== 1'b0 || fq_count !== 3'd0 || ifc.imem_req_addr !== 64'h8000_0000) begin
            tests_failed++;
            $display("FAIL midreset: req_valid=%b out_valid=%b fq_count=%0d addr=%h want 0/0/0/80000000", ifc.imem_req_valid, ifc.out_valid, fq_count, ifc.imem_req_addr);
        end
        rstn = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifc.out_valid === 1'b1 && n < 2) begin
                exp = 64'h8000_0000 + 64'(4 * n);
                tests_run++;
                if (ifc.out_pc !== exp) begin
                    tests_failed++;
                    $display("FAIL midreset_restart: pc=%h want %h", ifc.out_pc, exp);
                end
                n++;
            end
        end
        tests_run++;
        if (n !== 2) begin
            tests_failed++;
            $display("FAIL midreset_timeout: got %0d outputs want 2", n);
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [63:0] exp;
        do_reset(1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        redirect_en = 1'b1;
        @(negedge clk);
        redirect_en = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifc.out_valid === 1'b1 && n < 2) begin
                exp = 64'hFFFF_FFFF_FFFF_FFFC + 64'(4 * n);
                tests_run++;
                if (ifc.out_pc !== exp || ifc.out_snxt_pc !== exp + 64'd4 || ifc.out_instr !== memfn(exp)) begin
                    tests_failed++;
                    $display("FAIL wrap_out: pc=%h snxt=%h instr=%h want %h/%h/%h", ifc.out_pc, ifc.out_snxt_pc, ifc.out_instr, exp, exp + 64'd4, memfn(exp));
                end
                n++;
            end
        end
        tests_run++;
        if (n !== 2) begin
            tests_failed++;
            $display("FAIL wrap_timeout: got %0d outputs want 2", n);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_pc;
        logic [2:0]  exp_cnt;
        do_reset(1, 1'b1, 1'b1);
        @(negedge clk);
        tests_run++;
        if (ifc.out_valid !== BYP || fq_count !== 3'd0 || ifc.imem_rsp_instr !== NOP_INSTR) begin
            tests_failed++;
            $display("FAIL bypass_first: out_valid=%b fq_count=%0d rsp=%h want %b/0/00000013", ifc.out_valid, fq_count, ifc.imem_rsp_instr, BYP);
        end
        @(negedge clk);
        exp_pc  = BYP ? 64'h8000_0004 : 64'h8000_0000;
        exp_cnt = BYP ? 3'd0 : 3'd1;
        tests_run++;
        if (ifc.out_valid !== 1'b1 || ifc.out_pc !== exp_pc || fq_count !== exp_cnt) begin
            tests_failed++;
            $display("FAIL bypass_second: valid=%b pc=%h fq_count=%0d want 1/%h/%0d", ifc.out_valid, ifc.out_pc, fq_count, exp_pc, exp_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ifc.imem_req_ready = 1'b0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_reset_mid();
        test_wrap();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
